frame_seq_gen: RTL and testbench
================================

Name: frame_seq_gen

Overview:
Parametrised frame sequencer: the successor to the fixed 4/5-step APU frame counter. A binary step counter is compared against a programmable step table. It emits quarter-frame and half-frame strobes for the envelope, linear-counter, length and sweep units, and a frame IRQ. Step count, counter width, per-step strobe masks and write-to-reset delay are parameters, and the step table can be rewritten at runtime. It sits beside the register decoder and is clocked by ACLK.

Parameters:
CNT_W, 15, step counter width; the counter wraps at 2^CNT_W.
NSTEPS, 5, entries in the step table; mode 0 uses steps 0..NSTEPS-2, mode 1 uses steps 0..NSTEPS-1.
T_INIT, {18640,14914,11185,7456,3728}, reset value of the step table (NSTEPS x CNT_W), entry 0 in the LSBs.
Q_MASK0 / H_MASK0, 4'b1111 / 4'b1010, quarter/half strobe enable per step in mode 0 (bit i = step i).
Q_MASK1 / H_MASK1, 5'b10111 / 5'b10010, quarter/half strobe enable per step in mode 1.
WR_DELAY, 2, ACLK cycles from the control write to the counter restart (minimum 1).

Ports:
ACLK  in  1  sole clock, rising edge
n_RES  in  1  asynchronous active-low reset
W_CTRL  in  1  control write strobe, one cycle
DB_IN  in  8  control data: bit7 = mode, bit6 = IRQ inhibit
R_STAT  in  1  status read strobe; clears the IRQ flag
TBL_WE  in  1  step-table write strobe
TBL_IDX  in  $clog2(NSTEPS)  table entry index
TBL_DATA  in  CNT_W  table entry value
EXT_INT  in  1  external interrupt (DMC), ORed into INT_OUT
QFRAME  out  1  quarter-frame strobe, one cycle
HFRAME  out  1  half-frame strobe, one cycle
IRQ_FLAG  out  1  frame IRQ flag (status bit)
INT_OUT  out  1  IRQ_FLAG | EXT_INT, combinational
CNT  out  CNT_W  current counter value, for debug and verification

Behaviour:
- Reset (n_RES low, asynchronous): cnt=0, step index idx=0, mode=0, inhibit=0, IRQ_FLAG=0, QFRAME=HFRAME=0, table=T_INIT, no pending restart.
- Every ACLK: cnt <= cnt+1, wrapping modulo 2^CNT_W.
- Step match: when cnt==T[idx], on the next edge:
  - QFRAME <= Q_MASKm[idx], HFRAME <= H_MASKm[idx], where m is the current mode.
  - Latency from the match cycle to the strobe is exactly 1 cycle. Strobes last 1 cycle.
- Last step: last = NSTEPS-2 in mode 0, NSTEPS-1 in mode 1.
  - Matching the last step sets idx=0 and cnt=0 on the same edge.
  - Other matches set idx=idx+1.
- IRQ set: mode 0, last step matched, and inhibit=0 -> IRQ_FLAG <= 1 on the strobe edge.
- Only T[idx] is compared. A non-monotonic table means the counter must wrap through 2^CNT_W before the next match; this is legal and is not an error.
- Control write (W_CTRL=1):
  - mode and inhibit registers load on the next edge.
  - Inhibit=1 clears IRQ_FLAG on that same edge.
  - Arms a restart of WR_DELAY cycles.
  - When the delay expires: cnt=0, idx=0. If the new mode is 1, QFRAME=HFRAME=1 for one cycle on that same edge.
  - While the restart is pending, the counter and steps keep running under the new mode.
  - A second W_CTRL while pending restarts the delay, using the latest data.
- Status read: R_STAT clears IRQ_FLAG on the next edge.
- Precedence on the IRQ flag in the same cycle: IRQ set beats R_STAT clear; inhibit clear beats IRQ set.
- Table write: TBL_WE writes T[TBL_IDX] <= TBL_DATA, effective for comparisons from the next cycle. TBL_IDX >= NSTEPS is ignored. A write to the entry currently being compared applies immediately.
- A restart expiring in the same cycle as a step match: the restart wins, and no strobes from the match are issued.
- Reset asserted mid-sequence aborts all pending restarts and strobes.

Decomposition:
- Shared package frame_seq_pkg holds:
  - the control-bit positions (CTRL_MODE=7, CTRL_INH=6)
  - the default NTSC table and masks
  - the mode enum (MODE_4STEP, MODE_5STEP)
- One sub-module, frame_seq_delay: the WR_DELAY down-counter with retrigger and an expire pulse.
- The counter, table and IRQ logic stay in frame_seq_gen.

Test Plan:
- Reset, then program the table to {4,8,12,16,20}, mode 0 -> QFRAME at cnt matches 4,8,12,16 (one cycle later); HFRAME at matches 8,16; IRQ_FLAG=1 after match 16; cnt restarts at 0.
- Mode 1 via W_CTRL with DB_IN=0x80, same table -> after 2 cycles cnt=0 and QFRAME=HFRAME=1 together. Then QFRAME at 4,8,12,20; HFRAME at 8,20; no QFRAME at 16; IRQ_FLAG never set.
- Mode 0 with IRQ_FLAG=1 -> R_STAT pulse clears it. R_STAT in the same cycle as the match at 16 -> flag stays 1.
- W_CTRL with 0x40 while IRQ_FLAG=1 -> flag clears on the next edge. The next match at 16 does not set it. EXT_INT=1 still drives INT_OUT=1.
- Second W_CTRL one cycle after the first -> exactly one restart, 2 cycles after the second write, using the second write's mode.
- TBL_WE with idx=1, data=6 while idx=1 and cnt=5 -> QFRAME follows the match at cnt 6. TBL_IDX=7 is ignored. n_RES pulsed mid-sequence -> all outputs 0 and the table back to T_INIT.

Source files
------------

// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame sequencer: control-bit positions, NTSC default
// step table and strobe masks, and the sequencing mode.
package frame_seq_pkg;

    localparam int CTRL_MODE = 7;
    localparam int CTRL_INH  = 6;

    localparam int NTSC_CNT_W  = 15;
    localparam int NTSC_NSTEPS = 5;

    // Entry 0 sits in the LSBs.
    localparam logic [NTSC_NSTEPS*NTSC_CNT_W-1:0] NTSC_TABLE =
        {15'd18640, 15'd14914, 15'd11185, 15'd7456, 15'd3728};

    localparam logic [NTSC_NSTEPS-2:0] NTSC_Q_MASK0 = 4'b1111;
    localparam logic [NTSC_NSTEPS-2:0] NTSC_H_MASK0 = 4'b1010;
    localparam logic [NTSC_NSTEPS-1:0] NTSC_Q_MASK1 = 5'b10111;
    localparam logic [NTSC_NSTEPS-1:0] NTSC_H_MASK1 = 5'b10010;

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } mode_e;

endpackage

// File: rtl/frame_seq_delay.sv
// Retriggerable write-to-restart delay: counts WR_DELAY edges after the last
// start and pulses expire_o during the cycle before the restart edge.
module frame_seq_delay #(
    parameter int WR_DELAY = 2
) (
    input  logic ACLK,
    input  logic n_RES,
    input  logic start_i,
    output logic expire_o
);

    localparam int DW = $clog2(WR_DELAY + 1);

    logic [DW-1:0] dly_q, dly_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dly_d = dly_q;
        if (start_i) begin
            dly_d = DW'(WR_DELAY);
        end else if (dly_q != '0) begin
            dly_d = dly_q - DW'(1);
        end
    end

    // A new start in the final cycle retriggers instead of expiring.
    assign expire_o = (dly_q == DW'(1)) && !start_i;

    always_ff @(posedge ACLK or negedge n_RES) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!n_RES) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

endmodule

// File: rtl/frame_seq_gen.sv
// Parametrised APU frame sequencer: a free-running step counter compared against a
// programmable step table, producing quarter/half-frame strobes and the frame IRQ.
module frame_seq_gen
    import frame_seq_pkg::*;
#(
    parameter int                        CNT_W    = 15,
    parameter int                        NSTEPS   = 5,
    parameter logic [NSTEPS*CNT_W-1:0]   T_INIT   = NTSC_TABLE,
    parameter logic [NSTEPS-2:0]         Q_MASK0  = NTSC_Q_MASK0,
    parameter logic [NSTEPS-2:0]         H_MASK0  = NTSC_H_MASK0,
    parameter logic [NSTEPS-1:0]         Q_MASK1  = NTSC_Q_MASK1,
    parameter logic [NSTEPS-1:0]         H_MASK1  = NTSC_H_MASK1,
    parameter int                        WR_DELAY = 2
) (
    input  logic                      ACLK,
    input  logic                      n_RES,
    input  logic                      W_CTRL,
    input  logic [7:0]                DB_IN,
    input  logic                      R_STAT,
    input  logic                      TBL_WE,
    input  logic [$clog2(NSTEPS)-1:0] TBL_IDX,
    input  logic [CNT_W-1:0]          TBL_DATA,
    input  logic                      EXT_INT,
    output logic                      QFRAME,
    output logic                      HFRAME,
    output logic                      IRQ_FLAG,
    output logic                      INT_OUT,
    output logic [CNT_W-1:0]          CNT
);

    localparam int                IDX_W = $clog2(NSTEPS);
    localparam logic [IDX_W-1:0] LAST0 = IDX_W'(NSTEPS - 2);
    localparam logic [IDX_W-1:0] LAST1 = IDX_W'(NSTEPS - 1);

    logic [CNT_W-1:0] tbl_q [NSTEPS];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    mode_e            mode_q, mode_d;
    logic             inh_q, inh_d;
    logic             irq_q, irq_d;
    logic             qframe_q, qframe_d;
    logic             hframe_q, hframe_d;

    logic              restart;
    logic              step_match;
    logic              is_last;
    logic              irq_set;
    logic [NSTEPS-1:0] q_mask, h_mask;
    logic              unused_db;

    assign unused_db = ^DB_IN[5:0];

    frame_seq_delay #(
        .WR_DELAY (WR_DELAY)
    ) u_delay (
        .ACLK     (ACLK),
        .n_RES    (n_RES),
        .start_i  (W_CTRL),
        .expire_o (restart)
    );

    // Mode 0 never reaches the final entry, so its masks are zero-extended.
    assign q_mask     = (mode_q == MODE_5STEP) ? Q_MASK1 : {1'b0, Q_MASK0};
    assign h_mask     = (mode_q == MODE_5STEP) ? H_MASK1 : {1'b0, H_MASK0};
    assign step_match = (cnt_q == tbl_q[idx_q]);
    assign is_last    = (idx_q >= ((mode_q == MODE_5STEP) ? LAST1 : LAST0));

    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        mode_d   = mode_q;
        inh_d    = inh_q;
        irq_d    = irq_q;
        qframe_d = 1'b0;
        hframe_d = 1'b0;
        irq_set  = 1'b0;

        // An expiring restart swallows any step match in the same cycle.
        if (restart) begin
            cnt_d = '0;
            idx_d = '0;
            if (mode_q == MODE_5STEP) begin
                qframe_d = 1'b1;
                hframe_d = 1'b1;
            end
        end else if (step_match) begin
            qframe_d = q_mask[idx_q];
            hframe_d = h_mask[idx_q];
            if (is_last) begin
                cnt_d   = '0;
                idx_d   = '0;
                irq_set = (mode_q == MODE_4STEP) && !inh_q;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (W_CTRL) begin
            mode_d = mode_e'(DB_IN[CTRL_MODE]);
            inh_d  = DB_IN[CTRL_INH];
        end

        // Inhibit clear beats IRQ set, which beats the status-read clear.
        if (W_CTRL && DB_IN[CTRL_INH]) begin
            irq_d = 1'b0;
        end else if (irq_set) begin
            irq_d = 1'b1;
        end else if (R_STAT) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge n_RES) begin
        if (!n_RES) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            mode_q   <= MODE_4STEP;
            inh_q    <= 1'b0;
            irq_q    <= 1'b0;
            qframe_q <= 1'b0;
            hframe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            inh_q    <= inh_d;
            irq_q    <= irq_d;
            qframe_q <= qframe_d;
            hframe_q <= hframe_d;
        end
    end

    always_ff @(posedge ACLK or negedge n_RES) begin
        // NOTE: the table is a handful of flops with a defined power-up value, so it is reset, unlike a RAM.
        if (!n_RES) begin
            for (int i = 0; i < NSTEPS; i++) begin
                tbl_q[i] <= T_INIT[i*CNT_W +: CNT_W];
            end
        end else if (TBL_WE && (int'(TBL_IDX) < NSTEPS)) begin
            tbl_q[TBL_IDX] <= TBL_DATA;
        end
    end

    assign QFRAME   = qframe_q;
    assign HFRAME   = hframe_q;
    assign IRQ_FLAG = irq_q;
    assign INT_OUT  = irq_q | EXT_INT;
    assign CNT      = cnt_q;

endmodule

// File: tb/tb_frame_seq_gen.sv
// Self-checking bench for frame_seq_gen: expected strobes are queued as stimulus is
// applied and checked by a monitor; each scenario task checks flags and counter inline.
module tb_frame_seq_gen;

    typedef struct packed {
        logic        q;
        logic        h;
        logic [14:0] cnt;
    } strobe_t;

    logic        ACLK;
    logic        n_RES;
    logic        W_CTRL;
    logic [7:0]  DB_IN;
    logic        R_STAT;
    logic        TBL_WE;
    logic [2:0]  TBL_IDX;
    logic [14:0] TBL_DATA;
    logic        EXT_INT;
    logic        QFRAME;
    logic        HFRAME;
    logic        IRQ_FLAG;
    logic        INT_OUT;
    logic [14:0] CNT;

    int      checks   = 0;
    int      failures = 0;
    strobe_t sb[$];
    strobe_t mon_got;
    strobe_t mon_want;

    frame_seq_gen dut (
        .ACLK     (ACLK),
        .n_RES    (n_RES),
        .W_CTRL   (W_CTRL),
        .DB_IN    (DB_IN),
        .R_STAT   (R_STAT),
        .TBL_WE   (TBL_WE),
        .TBL_IDX  (TBL_IDX),
        .TBL_DATA (TBL_DATA),
        .EXT_INT  (EXT_INT),
        .QFRAME   (QFRAME),
        .HFRAME   (HFRAME),
        .IRQ_FLAG (IRQ_FLAG),
        .INT_OUT  (INT_OUT),
        .CNT      (CNT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Every strobe the DUT emits must match the oldest queued expectation.
    always @(negedge ACLK) begin
        if (n_RES === 1'b1 && (QFRAME === 1'b1 || HFRAME === 1'b1)) begin
            mon_got.q   = QFRAME;
            mon_got.h   = HFRAME;
            mon_got.cnt = CNT;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe got q=%b h=%b cnt=%0d, none expected",
                         mon_got.q, mon_got.h, mon_got.cnt);
            end else begin
                mon_want = sb.pop_front();
                if (mon_got !== mon_want) begin
                    failures++;
                    $display("FAIL strobe got q=%b h=%b cnt=%0d exp q=%b h=%b cnt=%0d",
                             mon_got.q, mon_got.h, mon_got.cnt, mon_want.q, mon_want.h, mon_want.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    task automatic expect_strobe(input logic q, input logic h, input logic [14:0] c);
        strobe_t s;
        s.q   = q;
        s.h   = h;
        s.cnt = c;
        sb.push_back(s);
    endtask

    // Strobes of one frame of the {4,8,12,16,20} table: same pattern for mode 0 and mode 1.
    task automatic expect_frame();
        expect_strobe(1'b1, 1'b0, 15'd5);
        expect_strobe(1'b1, 1'b1, 15'd9);
        expect_strobe(1'b1, 1'b0, 15'd13);
        expect_strobe(1'b1, 1'b1, 15'd0);
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (sb.size() != 0 && n < budget);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s pending_strobes got=%0d exp=0 after %0d cycles", name, sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic wait_cnt(input logic [14:0] target, input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (CNT !== target && n < budget);
        checks++;
        if (CNT !== target) begin
            failures++;
            $display("FAIL %s cnt got=%0d exp=%0d", name, CNT, target);
        end
    endtask

    task automatic test_reset();
        n_RES = 1'b0; W_CTRL = 1'b0; DB_IN = 8'h00; R_STAT = 1'b0; TBL_WE = 1'b0;
        TBL_IDX = 3'd0; TBL_DATA = 15'd0; EXT_INT = 1'b0;
        repeat (3) tick();
        checks++;
        if ({QFRAME, HFRAME, IRQ_FLAG, INT_OUT} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000", {QFRAME, HFRAME, IRQ_FLAG, INT_OUT});
        end
        checks++;
        if (CNT !== 15'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", CNT); end
    endtask

    task automatic test_mode0();
        expect_frame();
        n_RES  = 1'b1;
        TBL_WE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            TBL_IDX  = 3'(i);
            TBL_DATA = 15'(4 * (i + 1));
            tick();
        end
        TBL_WE = 1'b0;
        wait_empty(40, "mode0_frame");
        checks++;
        if (IRQ_FLAG !== 1'b1) begin failures++; $display("FAIL mode0_irq got=%b exp=1", IRQ_FLAG); end
        checks++;
        if (CNT !== 15'd0) begin failures++; $display("FAIL mode0_cnt_wrap got=%0d exp=0", CNT); end
        checks++;
        if (INT_OUT !== 1'b1) begin failures++; $display("FAIL mode0_int_out got=%b exp=1", INT_OUT); end
    endtask

    task automatic test_rstat();
        R_STAT = 1'b1;
        tick();
        R_STAT = 1'b0;
        checks++;
        if (IRQ_FLAG !== 1'b0) begin failures++; $display("FAIL rstat_clear got=%b exp=0", IRQ_FLAG); end
        expect_frame();
        wait_cnt(15'd16, 40, "rstat_reach16");
        R_STAT = 1'b1;
        tick();
        R_STAT = 1'b0;
        checks++;
        if (IRQ_FLAG !== 1'b1) begin failures++; $display("FAIL rstat_vs_set got=%b exp=1", IRQ_FLAG); end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rstat_frame pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_inhibit();
        W_CTRL = 1'b1;
        DB_IN  = 8'h40;
        tick();
        W_CTRL = 1'b0;
        checks++;
        if (IRQ_FLAG !== 1'b0) begin failures++; $display("FAIL inh_clear got=%b exp=0", IRQ_FLAG); end
        tick();
        checks++;
        if (CNT !== 15'd2) begin failures++; $display("FAIL inh_pending_cnt got=%0d exp=2", CNT); end
        tick();
        checks++;
        if (CNT !== 15'd0) begin failures++; $display("FAIL inh_restart_cnt got=%0d exp=0", CNT); end
        expect_frame();
        wait_empty(40, "inh_frame");
        checks++;
        if (IRQ_FLAG !== 1'b0) begin failures++; $display("FAIL inh_no_set got=%b exp=0", IRQ_FLAG); end
        EXT_INT = 1'b1;
        #1;
        checks++;
        if (INT_OUT !== 1'b1) begin failures++; $display("FAIL ext_int_or got=%b exp=1", INT_OUT); end
        EXT_INT = 1'b0;
        #1;
        checks++;
        if (INT_OUT !== 1'b0) begin failures++; $display("FAIL ext_int_low got=%b exp=0", INT_OUT); end
    endtask

    task automatic test_mode1();
        W_CTRL = 1'b1;
        DB_IN  = 8'h80;
        expect_strobe(1'b1, 1'b1, 15'd0);
        expect_frame();
        tick();
        W_CTRL = 1'b0;
        tick();
        tick();
        checks++;
        if (CNT !== 15'd0) begin failures++; $display("FAIL mode1_restart_cnt got=%0d exp=0", CNT); end
        wait_empty(40, "mode1_frame");
        checks++;
        if (IRQ_FLAG !== 1'b0) begin failures++; $display("FAIL mode1_irq got=%b exp=0", IRQ_FLAG); end
        checks++;
        if (CNT !== 15'd0) begin failures++; $display("FAIL mode1_cnt_wrap got=%0d exp=0", CNT); end
    endtask

    task automatic test_back_to_back();
        W_CTRL = 1'b1;
        DB_IN  = 8'h80;
        tick();
        DB_IN  = 8'h00;
        tick();
        W_CTRL = 1'b0;
        tick();
        checks++;
        if (CNT !== 15'd3) begin failures++; $display("FAIL b2b_no_early_restart got=%0d exp=3", CNT); end
        tick();
        checks++;
        if (CNT !== 15'd0) begin failures++; $display("FAIL b2b_restart got=%0d exp=0", CNT); end
        expect_frame();
        wait_empty(40, "b2b_frame");
        checks++;
        if (IRQ_FLAG !== 1'b1) begin failures++; $display("FAIL b2b_mode0_irq got=%b exp=1", IRQ_FLAG); end
    endtask

    task automatic test_tbl_write();
        expect_strobe(1'b1, 1'b0, 15'd5);
        wait_cnt(15'd5, 20, "tbl_reach5");
        TBL_WE   = 1'b1;
        TBL_IDX  = 3'd1;
        TBL_DATA = 15'd6;
        expect_strobe(1'b1, 1'b1, 15'd7);
        tick();
        TBL_IDX  = 3'd7;
        TBL_DATA = 15'd13;
        tick();
        TBL_WE   = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL tbl_live_write pending got=%0d exp=0", sb.size());
            sb.delete();
        end
        expect_strobe(1'b1, 1'b0, 15'd13);
        expect_strobe(1'b1, 1'b1, 15'd0);
        wait_empty(40, "tbl_rest_of_frame");
        checks++;
        if (CNT !== 15'd0) begin failures++; $display("FAIL tbl_cnt_wrap got=%0d exp=0", CNT); end
    endtask

    task automatic test_reset_mid();
        expect_strobe(1'b1, 1'b0, 15'd5);
        wait_empty(20, "rstmid_first");
        W_CTRL = 1'b1;
        DB_IN  = 8'h80;
        expect_strobe(1'b1, 1'b1, 15'd7);
        tick();
        W_CTRL = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rstmid_mode1_step pending got=%0d exp=0", sb.size());
            sb.delete();
        end
        n_RES = 1'b0;
        #1;
        checks++;
        if ({QFRAME, HFRAME, IRQ_FLAG, INT_OUT} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b exp=0000", {QFRAME, HFRAME, IRQ_FLAG, INT_OUT});
        end
        checks++;
        if (CNT !== 15'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", CNT); end
        repeat (2) tick();
        n_RES = 1'b1;
        repeat (3) tick();
        checks++;
        if (CNT !== 15'd3) begin failures++; $display("FAIL rstmid_no_restart got=%0d exp=3", CNT); end
        expect_strobe(1'b1, 1'b0, 15'd3729);
        wait_empty(4000, "rstmid_default_table");
        checks++;
        if (IRQ_FLAG !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%b exp=0", IRQ_FLAG); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_rstat();
        test_inhibit();
        test_mode1();
        test_back_to_back();
        test_tbl_write();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
